kp_i2s_tx: RTL and testbench

KP_I2S_TX -- requirements
Module: kp_i2s_tx

---
 rtl/kp_audio_pkg.sv | 21 ++
 rtl/kp_sample_fifo2.sv | 74 +++++++
 rtl/kp_i2s_tx.sv | 193 +++++++++++++++++++
 tb/tb_kp_i2s_tx.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kp_audio_pkg.sv
// Shared audio constants and the transmitter state type used by the I2S
// transmitter and its sample FIFO.
package kp_audio_pkg;

    localparam int SAMPLE_BITS = 24;
    localparam int SLOT_BITS   = 32;
    localparam int FRAME_BITS  = 64;
    localparam int BIT_W       = $clog2(FRAME_BITS);
    localparam int IDX_W       = $clog2(SAMPLE_BITS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

    // Word select for bit index b, one-bit delayed relative to the slot start.
    function automatic logic lrclk_for(input logic [BIT_W-1:0] b);
        return (b >= BIT_W'(SLOT_BITS - 1)) && (b <= BIT_W'(FRAME_BITS - 2));
    endfunction

endpackage

// File: rtl/kp_sample_fifo2.sv
// Two-entry sample FIFO with flush and a registered not-full ready flag.
module kp_sample_fifo2
    import kp_audio_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [SAMPLE_BITS-1:0] din,
    input  logic                   pop,
    output logic [SAMPLE_BITS-1:0] head,
    output logic                   full,
    output logic                   empty,
    output logic                   ready
);

    logic [SAMPLE_BITS-1:0] mem_r [2];
    logic                   wr_ptr_r;
    logic                   rd_ptr_r;
    logic [1:0]             count_r;
    logic [1:0]             count_next_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   ready_r;

    assign full  = (count_r == 2'd2);
    assign empty = (count_r == 2'd0);
    assign head  = mem_r[rd_ptr_r];
    assign ready = ready_r;

    // Accepted operations and next occupancy; flush discards a coincident push.
    always_comb begin
        push_s       = push && !full && !flush;
        pop_s        = pop && !empty && !flush;
        count_next_s = count_r;
        if (flush) begin
            count_next_s = 2'd0;
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + 2'd1;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - 2'd1;
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage, pointers and ready flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            ready_r  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_r <= 1'b0;
                rd_ptr_r <= 1'b0;
            end else begin
                if (push_s) begin
                    mem_r[wr_ptr_r] <= din;
                    wr_ptr_r        <= ~wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= ~rd_ptr_r;
                end
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != 2'd2);
        end
    end

endmodule

// File: rtl/kp_i2s_tx.sv
// Mono 24-bit I2S transmitter: duplicates each FIFO sample into both slots.
// Define KP_I2S_UNDERRUN_CNT_EN to build the saturating underrun counter.
module kp_i2s_tx
    import kp_audio_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        a_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]       div_r;
    logic                   bclk_r;
    logic                   lrclk_r;
    logic                   sdata_r;
    logic                   underrun_r;
    logic [BIT_W-1:0]       b_r;
    logic [BIT_W-1:0]       b_next_s;
    logic [IDX_W-1:0]       idx_s;
    logic [SAMPLE_BITS-1:0] frame_r;
    logic [SAMPLE_BITS-1:0] head_s;
    tx_state_e              state_r;
    tx_state_e              state_next_s;
    logic                   tick_s;
    logic                   fall_s;
    logic                   boundary_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   ready_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   flush_s;
    logic                   under_s;
    logic                   sdata_next_s;
    logic                   unused_s;

    assign unused_s   = ^{sample_in[31:SAMPLE_BITS], full_s};
    assign tick_s     = (div_r == DIV_W'(CLK_DIV - 1));
    assign fall_s     = tick_s && bclk_r;
    assign b_next_s   = b_r + BIT_W'(1);
    assign boundary_s = fall_s && (b_r == BIT_W'(FRAME_BITS - 1));
    assign push_s     = sample_valid && ready_s;

    kp_sample_fifo2 u_fifo (
        .clk     (a_clk),
        .reset_n (reset_n),
        .flush   (flush_s),
        .push    (push_s),
        .din     (sample_in[SAMPLE_BITS-1:0]),
        .pop     (pop_s),
        .head    (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .ready   (ready_s)
    );

    // State register.
    always_ff @(posedge a_clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: decisions are taken only at the frame boundary.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (boundary_s && enable && !empty_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (boundary_s && !enable) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FIFO control and underrun detection at the frame boundary.
    always_comb begin
        pop_s   = boundary_s && enable && !empty_s;
        flush_s = 1'b0;
        under_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                flush_s = 1'b0;
                under_s = 1'b0;
            end
            ST_RUN: begin
                flush_s = boundary_s && !enable;
                under_s = boundary_s && enable && empty_s;
            end
            default: begin
                flush_s = 1'b0;
                under_s = 1'b0;
            end
        endcase
    end

    // Both slots share one index because the slot width is a power of two.
    always_comb begin
        idx_s        = IDX_W'(SAMPLE_BITS) - b_next_s[IDX_W-1:0];
        sdata_next_s = 1'b0;
        if (state_r != ST_RUN) begin
            sdata_next_s = 1'b0;
        end else if ((b_next_s >= BIT_W'(1)) && (b_next_s <= BIT_W'(SAMPLE_BITS))) begin
            sdata_next_s = frame_r[idx_s];
        end else if ((b_next_s >= BIT_W'(SLOT_BITS + 1)) &&
                     (b_next_s <= BIT_W'(SLOT_BITS + SAMPLE_BITS))) begin
            sdata_next_s = frame_r[idx_s];
        end else begin
            sdata_next_s = 1'b0;
        end
    end

    // Bit clock divider, bit index, serial outputs and frame latch.
    always_ff @(posedge a_clk) begin
        if (!reset_n) begin
            div_r      <= '0;
            bclk_r     <= 1'b0;
            b_r        <= '0;
            lrclk_r    <= 1'b0;
            sdata_r    <= 1'b0;
            frame_r    <= '0;
            underrun_r <= 1'b0;
        end else begin
            if (tick_s) begin
                div_r  <= '0;
                bclk_r <= ~bclk_r;
            end else begin
                div_r  <= div_r + DIV_W'(1);
                bclk_r <= bclk_r;
            end
            if (fall_s) begin
                b_r     <= b_next_s;
                lrclk_r <= lrclk_for(b_next_s);
                sdata_r <= sdata_next_s;
            end
            if (pop_s) begin
                frame_r <= head_s;
            end else if (flush_s) begin
                frame_r <= '0;
            end
            underrun_r <= under_s;
        end
    end

`ifdef KP_I2S_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_r;

    // Saturating underrun counter, cleared only by reset.
    always_ff @(posedge a_clk) begin
        if (!reset_n) begin
            underrun_cnt_r <= 16'h0000;
        end else if (under_s && (underrun_cnt_r != 16'hFFFF)) begin
            underrun_cnt_r <= underrun_cnt_r + 16'h0001;
        end else begin
            underrun_cnt_r <= underrun_cnt_r;
        end
    end

    assign underrun_cnt = underrun_cnt_r;
`else
    assign underrun_cnt = 16'h0000;
`endif

    assign sample_ready = ready_s;
    assign i2s_bclk     = bclk_r;
    assign i2s_lrclk    = lrclk_r;
    assign i2s_sdata    = sdata_r;
    assign underrun     = underrun_r;

endmodule

// File: tb/tb_kp_i2s_tx.sv
// Bench for kp_i2s_tx: a cycle-time model derived from the frame timing rules,
// checked every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_kp_i2s_tx;

    localparam int CLK_DIV = 2;
`ifdef KP_I2S_UNDERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        a_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] sample_in = 32'h0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        underrun;
    logic [15:0] underrun_cnt;

    kp_i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
        .a_clk        (a_clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 a_clk = ~a_clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Model state: time since reset release, sample queue, current frame.
    bit          m_valid = 1'b0;
    int          m_t = -1;
    int          m_b = 0;
    bit          m_fall = 1'b0;
    bit          m_run = 1'b0;
    logic [23:0] m_frame = 24'h0;
    logic [23:0] m_q[$];
    logic        m_bclk = 1'b0;
    logic        m_lr = 1'b0;
    logic        m_sd = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_under = 1'b0;
    logic [15:0] m_cnt = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic model_step();
        logic push_ok;
        logic flushed;
        int   n;
        push_ok = sample_valid && m_ready;
        flushed = 1'b0;
        m_fall  = 1'b0;
        m_under = 1'b0;
        if (!reset_n) begin
            m_t = -1; m_b = 0; m_run = 1'b0; m_frame = 24'h0; m_q.delete();
            m_bclk = 1'b0; m_lr = 1'b0; m_sd = 1'b0; m_ready = 1'b0; m_cnt = 16'h0;
            m_valid = 1'b1;
        end else begin
            m_t++;
            if (((m_t + 1) % CLK_DIV) == 0) begin
                n = (m_t + 1) / CLK_DIV;
                m_bclk = n[0];
                if ((n % 2) == 0) begin
                    m_fall = 1'b1;
                    m_b = (n / 2) % 64;
                    if (m_b == 0) begin
                        if (m_run && !enable) begin
                            m_run = 1'b0; m_q.delete(); m_frame = 24'h0; flushed = 1'b1;
                        end else if (enable && m_q.size() > 0) begin
                            m_frame = m_q.pop_front(); m_run = 1'b1;
                        end else if (enable && m_run) begin
                            m_under = 1'b1;
                            if (CNT_EN && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
                        end
                    end
                    m_lr = (m_b >= 31 && m_b <= 62);
                    if (m_run && m_b >= 1 && m_b <= 24) m_sd = m_frame[24 - m_b];
                    else if (m_run && m_b >= 33 && m_b <= 56) m_sd = m_frame[56 - m_b];
                    else m_sd = 1'b0;
                end
            end
            if (push_ok && !flushed) m_q.push_back(sample_in[23:0]);
            m_ready = (m_q.size() < 2);
        end
    endtask

    initial forever begin
        @(posedge a_clk);
        model_step();
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge a_clk);
        if (m_valid) begin
            chk("bclk", {31'h0, i2s_bclk}, {31'h0, m_bclk});
            chk("lrclk", {31'h0, i2s_lrclk}, {31'h0, m_lr});
            chk("sdata", {31'h0, i2s_sdata}, {31'h0, m_sd});
            chk("ready", {31'h0, sample_ready}, {31'h0, m_ready});
            chk("underrun", {31'h0, underrun}, {31'h0, m_under});
            chk("underrun_cnt", {16'h0, underrun_cnt}, {16'h0, m_cnt});
            if (underrun === 1'b1) pulses++;
        end
    end

    task automatic wait_fall();
        for (int k = 0; k < 4 * CLK_DIV; k++) begin
            @(negedge a_clk);
            if (m_fall) return;
        end
        timeout("wait_fall");
    endtask

    task automatic wait_b(input int target);
        for (int k = 0; k < 70; k++) begin
            wait_fall();
            if (m_b == target) return;
        end
        timeout("wait_b");
    endtask

    task automatic push(input logic [31:0] v);
        for (int k = 0; k < 50 && !sample_ready; k++) @(negedge a_clk);
        sample_in = v;
        sample_valid = 1'b1;
        @(negedge a_clk);
        sample_valid = 1'b0;
    endtask

    // Captures the DUT data bits of one frame (called just after a boundary).
    task automatic capture(input int drop_at, output logic [23:0] l,
                           output logic [23:0] r, output int z);
        l = 24'h0; r = 24'h0; z = 0;
        for (int i = 0; i < 64; i++) begin
            wait_fall();
            if (m_b >= 1 && m_b <= 24) l = {l[22:0], i2s_sdata};
            else if (m_b >= 33 && m_b <= 56) r = {r[22:0], i2s_sdata};
            else z += int'(i2s_sdata);
            if (m_b == drop_at) enable = 1'b0;
        end
    endtask

    logic [23:0] l, r;
    int          z, p0, falls;
    logic        prev;

    initial begin
        int last_b, last_l, bper, lper, ones;
        logic pb, pl;
        repeat (3) @(negedge a_clk);
        chk("rst_bclk", {31'h0, i2s_bclk}, 32'h0);
        chk("rst_ready", {31'h0, sample_ready}, 32'h0);
        reset_n = 1'b1;
        @(negedge a_clk);
        chk("ready_after_release", {31'h0, sample_ready}, 32'h1);

        // Idle timing.
        last_b = -1; last_l = -1; bper = 0; lper = 0; ones = 0;
        pb = i2s_bclk; pl = i2s_lrclk;
        for (int c = 0; c < 600; c++) begin
            @(negedge a_clk);
            if (!pb && i2s_bclk) begin
                if (last_b >= 0) bper = c - last_b;
                last_b = c;
            end
            if (!pl && i2s_lrclk) begin
                if (last_l >= 0) lper = c - last_l;
                last_l = c;
            end
            ones += int'(i2s_sdata);
            pb = i2s_bclk; pl = i2s_lrclk;
        end
        chk("bclk_period", bper, 32'd4);
        chk("lrclk_period", lper, 32'd256);
        chk("idle_sdata_ones", ones, 32'd0);

        // Single sample, enable dropped at b=40, flush of queued samples.
        push(32'h00ABCDEF);
        push(32'h00123456);
        enable = 1'b1;
        wait_b(0);
        push(32'h00654321);
        chk("ready_full", {31'h0, sample_ready}, 32'h0);
        capture(40, l, r, z);
        chk("abcdef_left", {8'h0, l}, 32'h00ABCDEF);
        chk("abcdef_right", {8'h0, r}, 32'h00ABCDEF);
        chk("abcdef_pad_ones", z, 32'd0);
        chk("ready_after_flush", {31'h0, sample_ready}, 32'h1);
        enable = 1'b1;
        capture(-1, l, r, z);
        chk("after_stop_frame", {8'h0, l | r}, 32'h0);
        capture(-1, l, r, z);
        chk("flushed_frame", {8'h0, l | r}, 32'h0);

        // Two samples then underrun.
        push(32'h00111111);
        push(32'h00222222);
        chk("ready_drop_2nd", {31'h0, sample_ready}, 32'h0);
        wait_b(0);
        p0 = pulses;
        capture(-1, l, r, z);
        chk("first_sample", {8'h0, r}, 32'h00111111);
        capture(-1, l, r, z);
        chk("second_sample", {8'h0, l}, 32'h00222222);
        capture(40, l, r, z);
        chk("repeat_sample", {8'h0, l}, 32'h00222222);
        repeat (3) @(negedge a_clk);
        chk("underrun_pulses", pulses - p0, 32'd1);
        chk("underrun_cnt_1", {16'h0, underrun_cnt}, CNT_EN ? 32'd1 : 32'd0);

        // Reset at b=10 mid-frame.
        enable = 1'b1;
        push(32'h000F0F0F);
        push(32'h000A0A0A);
        wait_b(0);
        wait_b(10);
        reset_n = 1'b0;
        @(negedge a_clk);
        chk("mid_rst_outs", {27'h0, i2s_bclk, i2s_lrclk, i2s_sdata, underrun, sample_ready}, 32'h0);
        chk("mid_rst_cnt", {16'h0, underrun_cnt}, 32'h0);
        reset_n = 1'b1;
        falls = 0; prev = i2s_bclk;
        for (int k = 0; k < 400 && !i2s_lrclk; k++) begin
            @(negedge a_clk);
            if (prev && !i2s_bclk) falls++;
            prev = i2s_bclk;
        end
        chk("falls_to_lrclk", falls, 32'd31);
        wait_b(0);
        capture(-1, l, r, z);
        chk("post_rst_frame", {8'h0, l | r}, 32'h0);

        // Underrun counter saturation.
        push(32'h005A5A5A);
        wait_b(0);
        wait_b(10);
`ifdef KP_I2S_UNDERRUN_CNT_EN
        @(posedge a_clk);
        #1;
        force dut.underrun_cnt_r = 16'hFFFD;
        m_cnt = 16'hFFFD;
        repeat (2) @(posedge a_clk);
        #1;
        release dut.underrun_cnt_r;
`endif
        p0 = pulses;
        repeat (4) wait_b(0);
        repeat (3) @(negedge a_clk);
        chk("sat_pulses", pulses - p0, 32'd4);
        chk("sat_cnt", {16'h0, underrun_cnt}, CNT_EN ? 32'h0000FFFF : 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
